when_priority_arbiter: RTL and testbench

WHEN_PRIORITY_ARBITER -- requirements
Module: when_priority_arbiter

---
 rtl/when_priority_arbiter.sv | 86 ++++++++
 tb/tb_when_priority_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/when_priority_arbiter.sv
// N-channel arbiter with a registered output stage. Requests are granted either by
// fixed priority (channel 0 highest) or by round-robin starting at rr_ptr.
module when_priority_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   io_in_valid,
  input  logic [N*W-1:0] io_in_data,
  output logic [N-1:0]   io_in_ready,
  input  logic           io_mode,
  output logic           io_out_valid,
  input  logic           io_out_ready,
  output logic [W-1:0]   io_out_data,
  output logic [IW-1:0]  io_out_idx,
  output logic [15:0]    io_xfer_count
);

  logic [W-1:0]  ch_data [N];
  logic [IW-1:0] rr_ptr;
  logic          any_req;
  logic          load;
  logic          accept;
  logic [IW-1:0] fixed_winner;
  logic [N-1:0]  rot_valid;
  logic [IW-1:0] rot_off;
  logic [IW:0]   rr_sum;
  logic [IW-1:0] rr_winner;
  logic [IW-1:0] winner;
  logic [IW-1:0] next_ptr;

  function automatic logic [IW-1:0] lowest_set(input logic [N-1:0] v);
    lowest_set = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IW'(i);
    end
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign ch_data[g] = io_in_data[g*W +: W];
  end

  assign any_req = |io_in_valid;
  assign load    = !io_out_valid || io_out_ready;
  // Reset gating keeps the handshake closed while the output stage is being cleared.
  assign accept  = reset_n && load && any_req;

  assign fixed_winner = lowest_set(io_in_valid);

  // Round-robin: rotate requests so rr_ptr lands at bit 0, pick the lowest, then un-rotate.
  assign rot_valid = N'({io_in_valid, io_in_valid} >> rr_ptr);
  assign rot_off   = lowest_set(rot_valid);
  assign rr_sum    = {1'b0, rr_ptr} + {1'b0, rot_off};
  assign rr_winner = (rr_sum >= (IW+1)'(N)) ? IW'(rr_sum - (IW+1)'(N)) : rr_sum[IW-1:0];

  assign winner   = io_mode ? rr_winner : fixed_winner;
  assign next_ptr = (winner == IW'(N - 1)) ? '0 : winner + IW'(1);

  always_comb begin
    io_in_ready = '0;
    if (accept) io_in_ready = N'(1) << winner;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      io_out_valid  <= 1'b0;
      io_out_data   <= '0;
      io_out_idx    <= '0;
      rr_ptr        <= '0;
      io_xfer_count <= '0;
    end else if (load) begin
      if (any_req) begin
        io_out_valid  <= 1'b1;
        io_out_data   <= ch_data[winner];
        io_out_idx    <= winner;
        rr_ptr        <= next_ptr;
        io_xfer_count <= io_xfer_count + 16'd1;
      end else begin
        io_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_when_priority_arbiter.sv
// Scoreboard bench for when_priority_arbiter: a behavioural model predicts grants,
// queues the expected output word, and each scenario task compares against the DUT.
module tb_when_priority_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   io_in_valid;
  logic [N*W-1:0] io_in_data;
  logic [N-1:0]   io_in_ready;
  logic           io_mode;
  logic           io_out_valid;
  logic           io_out_ready;
  logic [W-1:0]   io_out_data;
  logic [IW-1:0]  io_out_idx;
  logic [15:0]    io_xfer_count;

  when_priority_arbiter #(.N(N), .W(W), .IW(IW)) dut (
    .clk(clk), .reset_n(reset_n),
    .io_in_valid(io_in_valid), .io_in_data(io_in_data), .io_in_ready(io_in_ready),
    .io_mode(io_mode),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_data(io_out_data), .io_out_idx(io_out_idx), .io_xfer_count(io_xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [W-1:0]  data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        m_item;
  exp_t        got;
  int          n_checks = 0;
  int          n_pass = 0;
  int          m_ptr = 0;
  int          m_count = 0;
  int          m_win;
  bit          m_valid = 0;
  bit          m_accept = 0;
  bit          m_load = 0;
  logic [W-1:0]  m_data = '0;
  logic [IW-1:0] m_idx = '0;
  logic [N-1:0]  exp_ready;

  function automatic int model_winner(input logic [N-1:0] v, input bit mode, input int ptr);
    int start = mode ? ptr : 0;
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic mode,
                       input logic ordy);
    io_in_valid  = v;
    io_in_data   = d;
    io_mode      = mode;
    io_out_ready = ordy;
    #1;
    m_win    = model_winner(v, mode, m_ptr);
    m_load   = !m_valid || ordy;
    m_accept = (reset_n === 1'b1) && m_load && (m_win >= 0);
    exp_ready = '0;
    if (m_accept) begin
      exp_ready   = N'(1) << m_win;
      m_item.idx  = IW'(m_win);
      m_item.data = d[m_win*W +: W];
      sb_q.push_back(m_item);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (reset_n !== 1'b1) begin
      m_valid = 0; m_ptr = 0; m_count = 0; m_data = '0; m_idx = '0;
    end else if (m_accept) begin
      m_valid = 1; m_ptr = (m_win + 1) % N; m_count = (m_count + 1) & 16'hFFFF;
      m_data = m_item.data; m_idx = m_item.idx;
    end else if (m_load) begin
      m_valid = 0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(4'b1111, 32'hDEADBEEF, 1'b1, 1'b1);
    n_checks++;
    if (io_in_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", io_in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if ({io_out_valid, io_out_data, io_out_idx, io_xfer_count} !== '0)
      $display("FAIL reset_outputs: got v=%b d=%h i=%0d c=%0d expected all zero",
               io_out_valid, io_out_data, io_out_idx, io_xfer_count);
    else n_pass++;
    reset_n = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_fixed();
    logic [N-1:0] pats [4] = '{4'b1010, 4'b1100, 4'b1000, 4'b0111};
    for (int k = 0; k < 4; k++) begin
      drive(pats[k], {8'h44 + 8'(k), 8'h33, 8'h22 + 8'(k), 8'h11}, 1'b0, 1'b1);
      n_checks++;
      if (io_in_ready !== exp_ready)
        $display("FAIL fixed_ready k=%0d: got %b expected %b", k, io_in_ready, exp_ready);
      else n_pass++;
      if (k == 0) begin
        n_checks++;
        if (io_in_ready !== 4'b0010) $display("FAIL fixed_ready_1010: got %b expected 0010", io_in_ready);
        else n_pass++;
      end
      tick();
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL fixed_sb_empty k=%0d: got empty queue expected one entry", k);
        continue;
      end
      got = sb_q.pop_front();
      n_checks++;
      if (io_out_idx !== got.idx || io_out_data !== got.data || io_out_valid !== 1'b1)
        $display("FAIL fixed_out k=%0d: got i=%0d d=%h v=%b expected i=%0d d=%h v=1",
                 k, io_out_idx, io_out_data, io_out_valid, got.idx, got.data);
      else n_pass++;
      n_checks++;
      if (io_xfer_count !== 16'(m_count))
        $display("FAIL fixed_count k=%0d: got %0d expected %0d", k, io_xfer_count, m_count);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, {8'hD0 + 8'(k), 8'hC0 + 8'(k), 8'hB0 + 8'(k), 8'hA0 + 8'(k)}, 1'b1, 1'b1);
      tick();
      got = sb_q.pop_front();
      n_checks++;
      if (io_out_idx !== IW'(k % N) || io_out_data !== got.data)
        $display("FAIL rr_seq k=%0d: got i=%0d d=%h expected i=%0d d=%h",
                 k, io_out_idx, io_out_data, k % N, got.data);
      else n_pass++;
    end
    n_checks++;
    if (io_xfer_count !== 16'd5) $display("FAIL rr_count: got %0d expected 5", io_xfer_count);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    drive(4'b0100, {8'h01, 8'hA5, 8'h02, 8'h03}, 1'b0, 1'b1);
    tick();
    void'(sb_q.pop_front());
    n_checks++;
    if (io_out_data !== 8'hA5 || io_out_idx !== 2'd2)
      $display("FAIL bp_capture: got d=%h i=%0d expected d=a5 i=2", io_out_data, io_out_idx);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      drive(4'b1111, {8'h5A, 8'h6B + 8'(k), 8'h7C, 8'h8D}, 1'b0, 1'b0);
      n_checks++;
      if (io_in_ready !== 4'b0000) $display("FAIL bp_ready k=%0d: got %b expected 0000", k, io_in_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (io_out_data !== 8'hA5 || io_out_idx !== 2'd2 || io_out_valid !== 1'b1 ||
          io_xfer_count !== 16'(m_count))
        $display("FAIL bp_hold k=%0d: got d=%h i=%0d v=%b c=%0d expected d=a5 i=2 v=1 c=%0d",
                 k, io_out_data, io_out_idx, io_out_valid, io_xfer_count, m_count);
      else n_pass++;
    end
    drive(4'b0000, 32'hFFFFFFFF, 1'b0, 1'b1);
    tick();
    n_checks++;
    if (io_out_valid !== 1'b0 || io_out_data !== 8'hA5)
      $display("FAIL idle_drain: got v=%b d=%h expected v=0 d=a5", io_out_valid, io_out_data);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 60; k++) begin
      drive(N'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0));
      n_checks++;
      if (io_in_ready !== exp_ready)
        $display("FAIL b2b_ready k=%0d: got %b expected %b", k, io_in_ready, exp_ready);
      else n_pass++;
      tick();
      if (m_accept) void'(sb_q.pop_front());
      n_checks++;
      if (io_out_valid !== 1'(m_valid) || (m_valid && (io_out_data !== m_data || io_out_idx !== m_idx)) ||
          io_xfer_count !== 16'(m_count))
        $display("FAIL b2b_out k=%0d: got v=%b d=%h i=%0d c=%0d expected v=%b d=%h i=%0d c=%0d",
                 k, io_out_valid, io_out_data, io_out_idx, io_xfer_count,
                 m_valid, m_data, m_idx, m_count);
      else n_pass++;
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    for (int k = 0; k < 65535; k++) begin
      drive(4'b0001, 32'h000000AA, 1'b0, 1'b1);
      tick();
      void'(sb_q.pop_front());
    end
    n_checks++;
    if (io_xfer_count !== 16'hFFFF) $display("FAIL wrap_preload: got %h expected ffff", io_xfer_count);
    else n_pass++;
    drive(4'b0001, 32'h000000AB, 1'b0, 1'b1);
    tick();
    void'(sb_q.pop_front());
    n_checks++;
    if (io_xfer_count !== 16'h0000) $display("FAIL wrap_zero: got %h expected 0000", io_xfer_count);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(4'b1111, 32'h44332211, 1'b1, 1'b1);
      tick();
      void'(sb_q.pop_front());
    end
    n_checks++;
    if (io_out_idx !== 2'd2 || io_out_valid !== 1'b1)
      $display("FAIL mr_setup: got i=%0d v=%b expected i=2 v=1", io_out_idx, io_out_valid);
    else n_pass++;
    reset_n = 1'b0;
    drive(4'b1111, 32'h44332211, 1'b1, 1'b1);
    n_checks++;
    if (io_in_ready !== 4'b0000) $display("FAIL mr_ready: got %b expected 0000", io_in_ready);
    else n_pass++;
    tick();
    reset_n = 1'b1;
    n_checks++;
    if ({io_out_valid, io_out_data, io_out_idx, io_xfer_count} !== '0)
      $display("FAIL mr_outputs: got v=%b d=%h i=%0d c=%0d expected all zero",
               io_out_valid, io_out_data, io_out_idx, io_xfer_count);
    else n_pass++;
    drive(4'b1111, 32'h44332211, 1'b1, 1'b1);
    n_checks++;
    if (io_in_ready !== 4'b0001) $display("FAIL mr_first_grant: got %b expected 0001", io_in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (io_out_idx !== 2'd0 || io_out_data !== 8'h11)
      $display("FAIL mr_first_out: got i=%0d d=%h expected i=0 d=11", io_out_idx, io_out_data);
    else n_pass++;
  endtask

  initial begin
    reset_n      = 1'b0;
    io_in_valid  = '0;
    io_in_data   = '0;
    io_mode      = 1'b0;
    io_out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_count_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
